muller_c_proj_core: RTL and testbench
=====================================

Name: muller_c_proj_core

Overview:
- Clocked, formally checkable model of three 2-input Muller C-elements driven from a 6-bit input bus.
- Each channel's output follows its two inputs when they agree and holds otherwise.
- Also provides per-channel change pulses, saturating transition counters and a property-violation flag.
- Sits behind the user-project I/O bus as the core of the Muller-C project; it is the block a formal harness instantiates for cover/assert runs.

Parameters:
- NCH, 3, number of C-element channels; io_in width is 2*NCH.
- CNT_W, 8, width of each per-channel transition counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- io_in  input  2*NCH  channel k inputs: a_k = io_in[2k], b_k = io_in[2k+1].
- c_out  output  NCH  C-element outputs, bit k = channel k.
- change  output  NCH  one-cycle pulse when c_out[k] changed on the last edge.
- cnt_flat  output  NCH*CNT_W  per-channel transition counters; channel k at bits [k*CNT_W +: CNT_W].
- prop_fail  output  1  sticky flag; set if any C-element invariant is violated.

Behaviour:
- Reset (rst_n low, asynchronous, regardless of clk):
  - c_out = 0, change = 0, all counters = 0, prop_fail = 0.
  - Internal previous-input registers are cleared to 0.
- Release of reset is sampled synchronously; the first update occurs on the first rising clk edge with rst_n high.
- Per channel k, on each rising edge:
  - If a_k == b_k: c_out[k] <= a_k.
  - Else: c_out[k] holds.
  - Latency is one clock from inputs agreeing to c_out reflecting them.
- change[k] is registered: 1 in the cycle after c_out[k] toggled, 0 otherwise. It never stays high two cycles unless c_out toggles on consecutive edges.
- Counter k increments by 1 on each c_out[k] toggle and saturates at 2^CNT_W-1 (no wrap). Inputs toggling without the output toggling do not count.
- prop_fail is computed every edge from registered previous inputs and outputs. It is set if either of these occurs:
  - c_out[k] changed while the previous-cycle inputs disagreed.
  - c_out[k] differs from agreeing previous-cycle inputs.
- prop_fail is sticky; only reset clears it. In a correct implementation it stays 0 forever.
- Simultaneous transitions of a_k and b_k within one cycle:
  - Both move to the same value: treated as agreement; output follows.
  - Inputs swap (01->10): output holds.
- Channels are fully independent; no cross-channel interaction.
- Inputs are assumed synchronous to clk. No synchronizer is included; asynchronous sources must be synchronized upstream.
- Reset asserted mid-operation immediately clears all state, including saturated counters and the sticky flag.

Test Plan:
- Reset, then io_in=6'b110100 for one edge -> c_out=3'b100, change=3'b100 next cycle, cnt ch2=1, others 0, prop_fail=0.
- From c_out=3'b111, apply io_in=6'b100110 (all pairs disagree) for 5 edges -> c_out stays 3'b111, change=0, counters unchanged.
- Channel 0 toggled 00->11->00 repeatedly 300 times -> cnt ch0 saturates at 255, c_out[0] keeps following, no wrap.
- Channel 1 input swap 01->10 in one cycle -> c_out[1] holds, no change pulse.
- Assert rst_n low asynchronously between edges with nonzero counters -> all outputs 0 immediately, before the next clk edge.
- Random io_in for 10k cycles, compared against a reference model -> exact match of c_out, change and counters; prop_fail remains 0.

Source files
------------

// File: rtl/muller_c_proj_core.sv
// Clocked model of NCH two-input Muller C-elements with change pulses,
// saturating transition counters and a sticky invariant-violation flag.
module muller_c_proj_core #(
  parameter int NCH   = 3,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*NCH-1:0]     io_in,
  output logic [NCH-1:0]       c_out,
  output logic [NCH-1:0]       change,
  output logic [NCH*CNT_W-1:0] cnt_flat,
  output logic                 prop_fail
);

  logic [NCH-1:0]   a, b, c_next;
  logic [NCH-1:0]   c_q, c_prev, change_q;
  logic [NCH-1:0]   a_prev, b_prev;
  logic [CNT_W-1:0] cnt [NCH];
  logic             prop_fail_q, violation;

  always_comb begin
    a      = '0;
    b      = '0;
    c_next = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      a[k]      = io_in[2*k];
      b[k]      = io_in[2*k+1];
      c_next[k] = (a[k] == b[k]) ? a[k] : c_q[k];
    end
  end

  // Invariant check: the output produced on the last edge must be consistent
  // with the inputs that were sampled on that edge.
  always_comb begin
    violation = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (a_prev[k] == b_prev[k]) begin
        if (c_q[k] != a_prev[k]) violation = 1'b1;
      end else begin
        if (c_q[k] != c_prev[k]) violation = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= '0;
      c_prev      <= '0;
      change_q    <= '0;
      a_prev      <= '0;
      b_prev      <= '0;
      prop_fail_q <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) cnt[k] <= '0;
    end else begin
      c_q         <= c_next;
      c_prev      <= c_q;
      change_q    <= c_next ^ c_q;
      a_prev      <= a;
      b_prev      <= b;
      prop_fail_q <= prop_fail_q | violation;
      for (int unsigned k = 0; k < NCH; k++) begin
        if ((c_next[k] != c_q[k]) && (cnt[k] != '1)) cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int unsigned k = 0; k < NCH; k++) cnt_flat[k*CNT_W +: CNT_W] = cnt[k];
  end

  assign c_out     = c_q;
  assign change    = change_q;
  assign prop_fail = prop_fail_q;

endmodule

// File: tb/tb_muller_c_proj_core.sv
// Self-checking bench for muller_c_proj_core: directed scenarios plus a
// randomized run against a behavioural C-element reference model.
module tb_muller_c_proj_core;
  localparam int NCH   = 3;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                 clk;
  logic                 rst_n;
  logic [2*NCH-1:0]     io_in;
  logic [NCH-1:0]       c_out;
  logic [NCH-1:0]       change;
  logic [NCH*CNT_W-1:0] cnt_flat;
  logic                 prop_fail;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_c   [NCH];
  bit m_chg [NCH];
  int m_cnt [NCH];

  muller_c_proj_core #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_in    (io_in),
    .c_out    (c_out),
    .change   (change),
    .cnt_flat (cnt_flat),
    .prop_fail(prop_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] exp_c();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = m_c[k];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_chg();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = m_chg[k];
    return r;
  endfunction

  function automatic logic [NCH*CNT_W-1:0] exp_cnt();
    logic [NCH*CNT_W-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*CNT_W +: CNT_W] = m_cnt[k][CNT_W-1:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_c[k] = 0; m_chg[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // Drive one input vector through one rising edge and advance the model.
  task automatic step(input logic [2*NCH-1:0] v);
    bit a, b, old;
    io_in = v;
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      a = v[2*k]; b = v[2*k+1]; old = m_c[k];
      if (a == b) m_c[k] = a;
      m_chg[k] = (m_c[k] != old);
      if (m_chg[k] && m_cnt[k] < CMAX) m_cnt[k]++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if ({c_out, change, cnt_flat, prop_fail} !== '0) begin
      errors++;
      $display("FAIL reset_state: got c=%b chg=%b cnt=%h pf=%b, want all zero",
               c_out, change, cnt_flat, prop_fail);
    end
  endtask

  task automatic test_first_update();
    step(6'b110100);
    checks++;
    if (c_out !== 3'b100) begin errors++; $display("FAIL first_c_out: got %b want 100", c_out); end
    checks++;
    if (change !== 3'b100) begin errors++; $display("FAIL first_change: got %b want 100", change); end
    checks++;
    if (cnt_flat !== 24'h01_00_00) begin errors++; $display("FAIL first_cnt: got %h want 010000", cnt_flat); end
    checks++;
    if (prop_fail !== 1'b0) begin errors++; $display("FAIL first_prop: got %b want 0", prop_fail); end
  endtask

  task automatic test_hold_disagree();
    logic [NCH*CNT_W-1:0] saved;
    step(6'b111111);
    checks++;
    if (c_out !== 3'b111) begin errors++; $display("FAIL hold_setup: got %b want 111", c_out); end
    saved = exp_cnt();
    for (int i = 0; i < 5; i++) begin
      step(6'b100110);
      checks++;
      if (c_out !== 3'b111 || change !== 3'b000) begin
        errors++;
        $display("FAIL hold_edge%0d: got c=%b chg=%b want c=111 chg=000", i, c_out, change);
      end
    end
    checks++;
    if (cnt_flat !== saved) begin errors++; $display("FAIL hold_cnt: got %h want %h", cnt_flat, saved); end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] sat;
    sat = '1;
    for (int i = 0; i < 300; i++) begin
      step((i % 2 == 0) ? 6'b111100 : 6'b111111);
      checks++;
      if (c_out[0] !== ((i % 2 == 0) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL sat_follow%0d: got %b want %b", i, c_out[0], (i % 2 != 0));
      end
    end
    checks++;
    if (cnt_flat[CNT_W-1:0] !== sat) begin
      errors++; $display("FAIL sat_cnt0: got %0d want %0d", cnt_flat[CNT_W-1:0], CMAX);
    end
    checks++;
    if (cnt_flat !== exp_cnt()) begin errors++; $display("FAIL sat_all_cnt: got %h want %h", cnt_flat, exp_cnt()); end
  endtask

  task automatic test_swap();
    logic held;
    step(6'b110111);  // ch1 = (a=1,b=0)
    held = c_out[1];
    step(6'b111011);  // ch1 swaps to (a=0,b=1)
    checks++;
    if (c_out[1] !== held || change[1] !== 1'b0) begin
      errors++;
      $display("FAIL swap_hold: got c1=%b chg1=%b want c1=%b chg1=0", c_out[1], change[1], held);
    end
    checks++;
    if (c_out !== exp_c() || prop_fail !== 1'b0) begin
      errors++; $display("FAIL swap_all: got c=%b pf=%b want c=%b pf=0", c_out, prop_fail, exp_c());
    end
  endtask

  task automatic test_async_reset();
    step(6'b000000);
    checks++;
    if (cnt_flat === '0) begin errors++; $display("FAIL areset_pre: got cnt=%h want nonzero", cnt_flat); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({c_out, change, cnt_flat, prop_fail} !== '0) begin
      errors++;
      $display("FAIL areset_clear: got c=%b chg=%b cnt=%h pf=%b want all zero",
               c_out, change, cnt_flat, prop_fail);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      step(6'($urandom));
      checks++;
      if (c_out !== exp_c()) begin errors++; $display("FAIL rnd_c%0d: got %b want %b", i, c_out, exp_c()); end
      checks++;
      if (change !== exp_chg()) begin errors++; $display("FAIL rnd_chg%0d: got %b want %b", i, change, exp_chg()); end
      checks++;
      if (cnt_flat !== exp_cnt()) begin errors++; $display("FAIL rnd_cnt%0d: got %h want %h", i, cnt_flat, exp_cnt()); end
      checks++;
      if (prop_fail !== 1'b0) begin errors++; $display("FAIL rnd_prop%0d: got %b want 0", i, prop_fail); end
    end
  endtask

  initial begin
    test_reset();
    test_first_update();
    test_hold_disagree();
    test_saturation();
    test_swap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
